// File: rtl/t2mi_ts_slot_scheduler.sv
// Constant-rate 188-byte TS packet scheduler: NCO byte slots, T2-MI/null packet choice,
// header generation and a one-byte prefetch handshake towards the T2-MI packer.
module t2mi_ts_slot_scheduler #(
    parameter int NCO_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [NCO_W-1:0] RATE_INC,
    input  logic [12:0]      PID,
    input  logic             TS_AVAIL,
    output logic             PACK_ENA,
    input  logic             PACK_ENA_OUT,
    input  logic [7:0]       PACK_DATA,
    input  logic [7:0]       PACK_PTR,
    output logic [7:0]       TS_DATA,
    output logic             TS_ENA,
    output logic             TS_START,
    output logic [CNT_W-1:0] UNDERRUN_CNT,
    output logic [CNT_W-1:0] NULL_CNT
);

    typedef enum logic [1:0] {S_BOUND, S_HDR, S_PTRF, S_PAY} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NCO_W-1:0] acc;
    logic [NCO_W:0]   acc_sum;
    logic             tick;
    logic [7:0]       idx;
    logic             mode_t2mi;
    logic             pusi;
    logic [7:0]       ptr_field;
    logic [3:0]       cc;
    logic             pf_vld;
    logic [7:0]       pf_data;
    logic             fetch_wait;
    logic [7:0]       fetch_left;
    logic             pending;
    logic             load;
    logic             pay_t2mi;
    logic             consume;
    logic             emit;
    logic             last_byte;
    logic             underrun_inc;
    logic [7:0]       byte_val;
    logic             ts_ena_q;
    logic             ts_start_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign acc_sum   = {1'b0, acc} + {1'b0, RATE_INC};
    assign tick      = EN && acc_sum[NCO_W];
    assign pay_t2mi  = (state == S_PAY) && mode_t2mi;
    assign load      = EN && fetch_wait && PACK_ENA_OUT;
    assign consume   = pay_t2mi && emit;
    assign last_byte = emit && (state == S_PAY) && (idx == 8'd187);

    // Frozen handshake/output registers are masked so nothing leaves the block while EN=0.
    assign TS_ENA   = ts_ena_q && EN;
    assign TS_START = ts_start_q && EN;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_BOUND;
        else if (EN) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (emit) begin
            case (state)
                S_BOUND: state_nxt = S_HDR;
                S_HDR:   if (idx == 8'd3) state_nxt = (mode_t2mi && pusi) ? S_PTRF : S_PAY;
                S_PTRF:  state_nxt = S_PAY;
                S_PAY:   if (idx == 8'd187) state_nxt = S_BOUND;
                default: state_nxt = S_BOUND;
            endcase
        end
    end

    always_comb begin
        emit         = 1'b0;
        byte_val     = 8'h00;
        underrun_inc = 1'b0;
        case (state)
            S_BOUND: begin
                emit     = tick;
                byte_val = 8'h47;
            end
            S_HDR: begin
                emit = tick;
                if (idx == 8'd1)      byte_val = mode_t2mi ? {1'b0, pusi, 1'b0, PID[12:8]} : 8'h1F;
                else if (idx == 8'd2) byte_val = mode_t2mi ? PID[7:0] : 8'hFF;
                else                  byte_val = mode_t2mi ? {4'b0001, cc} : 8'h10;
            end
            S_PTRF: begin
                emit     = tick;
                byte_val = ptr_field;
            end
            S_PAY: begin
                if (mode_t2mi) begin
                    // A byte arriving from the packer this cycle is forwarded straight through.
                    emit         = EN && (tick || pending) && (pf_vld || load);
                    byte_val     = pf_vld ? pf_data : PACK_DATA;
                    underrun_inc = tick && (pending || !(pf_vld || load));
                end else begin
                    emit     = tick;
                    byte_val = 8'hFF;
                end
            end
            default: ;
        endcase
    end

    assign PACK_ENA = EN && (fetch_left != 8'd0) && !pf_vld && !fetch_wait;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc          <= '0;
            idx          <= 8'd0;
            mode_t2mi    <= 1'b0;
            pusi         <= 1'b0;
            ptr_field    <= 8'd0;
            cc           <= 4'd0;
            pf_vld       <= 1'b0;
            fetch_wait   <= 1'b0;
            fetch_left   <= 8'd0;
            pending      <= 1'b0;
            TS_DATA      <= 8'd0;
            ts_ena_q     <= 1'b0;
            ts_start_q   <= 1'b0;
            UNDERRUN_CNT <= '0;
            NULL_CNT     <= '0;
        end else if (EN) begin
            acc        <= acc_sum[NCO_W-1:0];
            ts_ena_q   <= emit;
            ts_start_q <= emit && (state == S_BOUND);
            fetch_wait <= PACK_ENA;
            if (emit) begin
                TS_DATA <= byte_val;
                idx     <= (idx == 8'd187) ? 8'd0 : idx + 8'd1;
            end
            if (emit && (state == S_BOUND)) begin
                mode_t2mi <= TS_AVAIL;
                pusi      <= (PACK_PTR <= 8'd182);
                ptr_field <= PACK_PTR;
            end
            if (emit && (state == S_HDR) && (idx == 8'd1) && mode_t2mi)
                fetch_left <= 8'd184 - {7'd0, pusi};
            else if (load)
                fetch_left <= fetch_left - 8'd1;
            if (consume)   pf_vld <= 1'b0;
            else if (load) pf_vld <= 1'b1;
            if (pay_t2mi) begin
                if (emit)      pending <= 1'b0;
                else if (tick) pending <= 1'b1;
            end
            if (last_byte && mode_t2mi)  cc       <= cc + 4'd1;
            if (last_byte && !mode_t2mi) NULL_CNT <= sat_inc(NULL_CNT);
            if (underrun_inc) UNDERRUN_CNT <= sat_inc(UNDERRUN_CNT);
        end
    end

    always_ff @(posedge CLK) begin
        if (EN && load && !consume) pf_data <= PACK_DATA;
    end

endmodule
